sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//   Shares the single SRAM controller between the image loader (write requester) and the
//   image generator (read requester, real-time display path). Accepts one request at a
//   time, sequences a single SRAM access, returns read data/completion. Read side has
//   priority; a streak limit guarantees the writer cannot starve.
// PARAMETERS
//   ADDR_W       20  SRAM word address width
//   DATA_W       16  SRAM data width
//   MAX_RD_RUN   8   consecutive read grants allowed while writer waits (>=1)
//   TIMEOUT_CYC  15  WAIT-state cycle limit (used only with SRAM_ARB_TIMEOUT_EN)
// PORTS
//   i_clk         in   1       system clock
//   i_rst         in   1       asynchronous reset, active-high
//   i_rd_req      in   1       read request; held until o_rd_ack
//   i_rd_addr     in   ADDR_W  read address, sampled on o_rd_ack
//   o_rd_ack      out  1       1-cycle pulse: read request accepted
//   o_rd_valid    out  1       1-cycle pulse: o_rd_data valid
//   o_rd_data     out  DATA_W  read data, held until next o_rd_valid
//   i_wr_req      in   1       write request; held until o_wr_ack
//   i_wr_addr     in   ADDR_W  write address, sampled on o_wr_ack
//   i_wr_data     in   DATA_W  write data, sampled on o_wr_ack
//   o_wr_ack      out  1       1-cycle pulse: write request accepted
//   o_wr_done     out  1       1-cycle pulse: write completed in SRAM
//   o_mem_read    out  1       1-cycle read strobe to SRAM controller
//   o_mem_write   out  1       1-cycle write strobe to SRAM controller
//   o_mem_addr    out  ADDR_W  address to controller, stable ISSUE..WAIT
//   o_mem_wdata   out  DATA_W  write data to controller, stable ISSUE..WAIT
//   i_mem_fin     in   1       controller done pulse (read data valid same cycle)
//   i_mem_rdata   in   DATA_W  controller read data
//   o_busy        out  1       high whenever state != IDLE
//   o_err         out  1       sticky timeout flag (0 when macro undefined)
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, run counter 0, latched addr/data 0. Reset mid-access
//     drops the access silently; no ack/valid/done is produced for it.
//   - FSM: IDLE -> ISSUE -> WAIT -> IDLE. One access in flight, never pipelined.
//   - IDLE: pick winner, pulse o_*_ack, latch addr/data and op type, go ISSUE. No req: stay.
//   - Arbitration (IDLE only): rd only -> read; wr only -> write; both -> read unless
//     run_cnt == MAX_RD_RUN, then write.
//   - run_cnt: +1 on read grant while i_wr_req high; cleared on write grant or any cycle
//     i_wr_req low; saturates at MAX_RD_RUN.
//   - ISSUE: pulse o_mem_read or o_mem_write for exactly 1 cycle; go WAIT. i_mem_fin in
//     ISSUE is ignored (controller contract: fin no earlier than cycle after strobe).
//   - WAIT: on i_mem_fin -> IDLE; read: o_rd_data <= i_mem_rdata, o_rd_valid pulse next
//     cycle; write: o_wr_done pulse next cycle. Same cycle new grant in IDLE is legal.
//   - Minimum access period 3 cycles (ack -> strobe -> fin); ack-to-valid >= 3 cycles.
//   - Requester may deassert req the cycle after ack or keep it high for the next access;
//     req dropped before ack is a withdrawn request, never granted.
//   - Address/data widths pass through unmodified; no wrap or arithmetic on addresses.
// CONFIGURATION
//   SRAM_ARB_TIMEOUT_EN defined: 5-bit-min wait counter clears on ISSUE; if TIMEOUT_CYC
//     cycles elapse in WAIT without i_mem_fin -> set o_err (sticky until i_rst), return
//     IDLE, emit o_rd_valid with o_rd_data = 0 (read) or o_wr_done (write) so requesters
//     never hang. Late i_mem_fin in IDLE ignored.
//   Undefined: WAIT holds indefinitely for i_mem_fin; o_err tied 0; no counter logic.
// TESTING
//   1 Single read: rd_req, addr 0x00123; fin after 2 cycles, rdata 0xBEEF -> ack@t0,
//     o_mem_read@t1 addr 0x00123, o_rd_valid@fin+1 data 0xBEEF, o_busy low after.
//   2 Single write: addr 0x0ABCD data 0x1234 -> ack, 1-cycle o_mem_write with those
//     values, o_wr_done 1 cycle after fin; no o_rd_valid.
//   3 Contention: both req held, MAX_RD_RUN=8, fin every 1 cycle -> grant order
//     R x8, W, R x8, W ...; run_cnt clears after each W.
//   4 Reset mid-WAIT of read: assert i_rst 1 cycle -> all outputs 0 immediately; later
//     fin ignored; no o_rd_valid; next rd_req served normally.
//   5 Timeout (macro on, TIMEOUT_CYC=15): read with no fin -> after 15 WAIT cycles
//     o_err=1, o_rd_valid with data 0, state IDLE; next access completes, o_err stays 1.
//   6 Withdrawn req: wr_req high 1 cycle during busy read then low -> never acked/issued.

Source files
------------

// File: rtl/sram_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Shares one SRAM controller between the image loader (writer) and the image
// generator (reader, real-time display path). Exactly one access is in flight
// at a time: IDLE -> ISSUE -> WAIT -> IDLE.
//
// Arbitration happens only in IDLE. Reads win over writes, except when the
// writer has already watched MAX_RD_RUN consecutive read grants. In that case
// the writer gets the next slot, so it can never starve.
//
// Optional feature (macro SRAM_ARB_TIMEOUT_EN):
//   When defined, a WAIT that lasts TIMEOUT_CYC cycles without i_mem_fin is
//   abandoned. o_err is set and stays set until reset. The requester still
//   gets its completion pulse (read data forced to 0), so it never hangs.
//   When undefined, WAIT holds until i_mem_fin and o_err is tied to 0.
//
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_rd_req/i_rd_addr         read request (held until o_rd_ack) and address
//   o_rd_ack                   1-cycle pulse, read accepted (address sampled)
//   o_rd_valid/o_rd_data       1-cycle valid pulse; data held until the next one
//   i_wr_req/i_wr_addr/i_wr_data  write request (held until o_wr_ack)
//   o_wr_ack                   1-cycle pulse, write accepted (addr/data sampled)
//   o_wr_done                  1-cycle pulse, write completed in SRAM
//   o_mem_read/o_mem_write     1-cycle strobes to the SRAM controller
//   o_mem_addr/o_mem_wdata     latched access address/data, stable ISSUE..WAIT
//   i_mem_fin/i_mem_rdata      controller completion pulse and read data
//   o_busy                     high whenever an access is in progress
//   o_err                      sticky timeout flag
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int MAX_RD_RUN  = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_wr_done,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_fin,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_err
);

  // Elaboration-time sanity checks on the configuration.
  if (MAX_RD_RUN < 1) begin : g_bad_run
    $error("sram_access_arbiter: MAX_RD_RUN must be >= 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("sram_access_arbiter: TIMEOUT_CYC must be >= 1");
  end

  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              op_read;      // latched op type of the access in flight
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_done;
  logic [RUN_W-1:0]  run_cnt;      // consecutive read grants while writer waits

  logic              grant_rd;
  logic              grant_wr;
  logic              fin_event;    // controller finished the access in WAIT
  logic              timeout_hit;  // WAIT abandoned this cycle
  logic              access_end;

  // ---------------------------------------------------------------------------
  // Optional WAIT timeout
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt;     // WAIT cycles already spent, minus one
  logic              err;

  // A fin arriving on the last allowed cycle still counts as a normal finish.
  assign timeout_hit = (state == S_WAIT) && !i_mem_fin && (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign o_err = err;
`else
  assign timeout_hit = 1'b0;
  assign o_err       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: next state and grant decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    fin_event = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Acks are combinational. They are gated by reset so that every
        // output reads 0 while reset is held, even with a request pending.
        if (!i_rst) begin
          if (i_rd_req && (!i_wr_req || (run_cnt != RUN_MAX))) begin
            grant_rd = 1'b1;
          end else if (i_wr_req) begin
            grant_wr = 1'b1;
          end
        end
        if (grant_rd || grant_wr) begin
          state_nxt = S_ISSUE;
        end
      end
      // i_mem_fin is never expected in ISSUE and is deliberately ignored.
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_mem_fin) begin
          fin_event = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign access_end = fin_event || timeout_hit;

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples pre-edge values no matter how blocks are ordered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Access latch: op type, address and write data captured on the grant
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_read   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_rd) begin
      op_read  <= 1'b1;
      mem_addr <= i_rd_addr;
    end else if (grant_wr) begin
      op_read   <= 1'b0;
      mem_addr  <= i_wr_addr;
      mem_wdata <= i_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: read data / valid and write done, one cycle after the finish
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      if (access_end) begin
        if (op_read) begin
          rd_valid <= 1'b1;
          // An abandoned read returns zero, not whatever is on the bus.
          rd_data  <= timeout_hit ? '0 : i_mem_rdata;
        end else begin
          wr_done <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Anti-starvation run counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_cnt <= '0;
    end else if (!i_wr_req || grant_wr) begin
      run_cnt <= '0;
    end else if (grant_rd && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_rd_ack    = grant_rd;
  assign o_wr_ack    = grant_wr;
  assign o_rd_valid  = rd_valid;
  assign o_rd_data   = rd_data;
  assign o_wr_done   = wr_done;
  assign o_mem_read  = (state == S_ISSUE) &&  op_read;
  assign o_mem_write = (state == S_ISSUE) && !op_read;
  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_busy      = (state != S_IDLE);

  // Structural invariants of the arbiter.
  a_single_ack : assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_rd_ack && o_wr_ack));
  a_single_strobe : assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_mem_read && o_mem_write));

endmodule

// File: tb/tb_sram_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
//
// Self-checking bench for sram_access_arbiter.
// A responder process models the SRAM controller: it sees a strobe, waits
// fin_delay cycles, then pulses i_mem_fin. Its memory array is updated on
// write completion.
// A monitor keeps a reference memory that is updated on write acceptance.
// On every read acceptance it pushes the expected data into a scoreboard
// queue. It pops and compares that data when o_rd_valid appears.
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ack;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              o_wr_done;
  logic              o_mem_read;
  logic              o_mem_write;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_fin;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy;
  logic              o_err;

  sram_access_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_RD_RUN (8),
    .TIMEOUT_CYC(15)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_req   (i_rd_req),
    .i_rd_addr  (i_rd_addr),
    .o_rd_ack   (o_rd_ack),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_wr_req   (i_wr_req),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_wr_ack   (o_wr_ack),
    .o_wr_done  (o_wr_done),
    .o_mem_read (o_mem_read),
    .o_mem_write(o_mem_write),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_fin  (i_mem_fin),
    .i_mem_rdata(i_mem_rdata),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] sram    [logic [ADDR_W-1:0]];  // controller-side memory
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];  // scoreboard reference
  logic [DATA_W-1:0] sb [$];                        // expected read data
  bit                grant_log [$];                 // 1 = read grant, 0 = write

  int rd_valid_cnt  = 0;
  int wr_ack_cnt    = 0;
  int wr_done_cnt   = 0;
  int mem_write_cnt = 0;
  int overlap_cnt   = 0;

  bit resp_en        = 1'b1;
  int fin_delay      = 1;
  bit inject_fin     = 1'b0;
  bit expect_timeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
    return sram.exists(a) ? sram[a] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Inputs change 1 time unit after the clock edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // SRAM controller model (drives at edge+1)
  // ---------------------------------------------------------------------------
  initial begin
    bit                pend = 1'b0;
    int                cnt  = 0;
    bit                pwr  = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pdata = '0;
    i_mem_fin   = 1'b0;
    i_mem_rdata = 16'hDEAD;
    forever begin
      step();
      i_mem_fin   = 1'b0;
      i_mem_rdata = 16'hDEAD;
      if (inject_fin) begin
        i_mem_fin  = 1'b1;
        inject_fin = 1'b0;
      end else if (pend) begin
        if (cnt == 1) begin
          i_mem_fin = 1'b1;
          pend      = 1'b0;
          if (pwr) sram[paddr] = pdata;
          else     i_mem_rdata = sram_rd(paddr);
        end else begin
          cnt--;
        end
      end
      if (resp_en && (o_mem_read || o_mem_write)) begin
        pend  = 1'b1;
        cnt   = fin_delay;
        pwr   = o_mem_write;
        paddr = o_mem_addr;
        pdata = o_mem_wdata;
      end
      if (i_rst) pend = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (samples at edge+2)
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (o_rd_ack) begin
        check("single_ack", o_wr_ack, 1'b0);
        grant_log.push_back(1'b1);
        sb.push_back(expect_timeout ? '0 : ref_rd(i_rd_addr));
      end
      if (o_wr_ack) begin
        grant_log.push_back(1'b0);
        ref_mem[i_wr_addr] = i_wr_data;
        wr_ack_cnt++;
      end
      if (o_rd_valid) begin
        rd_valid_cnt++;
        check("rd_valid_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) check("rd_data", o_rd_data, sb.pop_front());
      end
      if (o_wr_done)   wr_done_cnt++;
      if (o_mem_write) mem_write_cnt++;
      if (o_rd_valid && (o_rd_ack || o_wr_ack)) overlap_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (!o_busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_idle"}, done, 1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input string tag);
    bit got = 1'b0;
    step();
    i_rd_addr = addr;
    i_rd_req  = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (o_rd_ack) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_ack"}, got, 1);
    step();
    i_rd_req = 1'b0;
    wait_idle(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int saved_valid;
    int saved_wack;
    int saved_mw;
    int saved_wdone;
    bit got;

    sram[20'h00123]    = 16'hBEEF;  ref_mem[20'h00123] = 16'hBEEF;
    sram[20'h00010]    = 16'h7777;  ref_mem[20'h00010] = 16'h7777;

    i_rst     = 1'b1;
    i_rd_req  = 1'b1;             // pending request must not be acked in reset
    i_rd_addr = 20'h00123;
    i_wr_req  = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;

    // ---- reset state ----
    step();
    step();
    #1;
    check("rst_busy",     o_busy, 0);
    check("rst_ack",      o_rd_ack, 0);
    check("rst_valid",    o_rd_valid, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_rd_data",  o_rd_data, 0);
    check("rst_err",      o_err, 0);
    step();
    i_rd_req = 1'b0;
    i_rst    = 1'b0;

    // ---- 1: single read with detailed timing ----
    fin_delay = 2;
    step();
    i_rd_addr = 20'h00123;
    i_rd_req  = 1'b1;
    #1;
    check("t1_ack", o_rd_ack, 1);
    step();
    i_rd_req = 1'b0;
    #1;
    check("t1_strobe",  o_mem_read, 1);
    check("t1_no_wr",   o_mem_write, 0);
    check("t1_addr",    o_mem_addr, 20'h00123);
    check("t1_busy",    o_busy, 1);
    step();
    #1;
    check("t1_strobe_1cyc", o_mem_read, 0);
    n = 2;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      n++;
      if (o_rd_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("t1_valid_seen", got, 1);
    check("t1_latency",    n, 4);
    check("t1_data",       o_rd_data, 16'hBEEF);
    check("t1_idle_after", o_busy, 0);
    wait_idle("t1");

    // ---- 2: single write ----
    fin_delay   = 1;
    saved_valid = rd_valid_cnt;
    step();
    i_wr_addr = 20'h0ABCD;
    i_wr_data = 16'h1234;
    i_wr_req  = 1'b1;
    #1;
    check("t2_ack", o_wr_ack, 1);
    step();
    i_wr_req = 1'b0;
    #1;
    check("t2_strobe", o_mem_write, 1);
    check("t2_no_rd",  o_mem_read, 0);
    check("t2_addr",   o_mem_addr, 20'h0ABCD);
    check("t2_wdata",  o_mem_wdata, 16'h1234);
    n = 1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      n++;
      if (o_wr_done) begin
        got = 1'b1;
        break;
      end
    end
    check("t2_done_seen", got, 1);
    check("t2_latency",   n, 3);
    wait_idle("t2");
    check("t2_no_rd_valid", rd_valid_cnt, saved_valid);
    do_read(20'h0ABCD, "t2_readback");

    // ---- 3: contention, both requests held ----
    fin_delay   = 1;
    saved_wack  = wr_ack_cnt;
    saved_wdone = wr_done_cnt;
    overlap_cnt = 0;
    step();
    grant_log.delete();
    i_rd_addr = 20'h00010;
    i_wr_addr = 20'h00020;
    i_wr_data = 16'h5555;
    i_rd_req  = 1'b1;
    i_wr_req  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #2;
      if (grant_log.size() >= 20) begin
        got = 1'b1;
        break;
      end
      step();
    end
    step();
    i_rd_req = 1'b0;
    i_wr_req = 1'b0;
    check("t3_grants_seen", got, 1);
    for (int i = 0; i < 20; i++) begin
      if (i < grant_log.size())
        check($sformatf("t3_grant_%0d", i), grant_log[i], (i % 9 == 8) ? 1'b0 : 1'b1);
    end
    wait_idle("t3");
    check("t3_writes",       wr_ack_cnt - saved_wack, 2);
    check("t3_wr_done",      wr_done_cnt - saved_wdone, 2);
    check("t3_back_to_back", 32'(overlap_cnt > 0), 1);
    do_read(20'h00020, "t3_readback");

    // ---- 6: withdrawn write request during a busy read ----
    fin_delay  = 3;
    saved_wack = wr_ack_cnt;
    saved_mw   = mem_write_cnt;
    step();
    i_rd_addr = 20'h00123;
    i_rd_req  = 1'b1;
    #1;
    check("t6_rd_ack", o_rd_ack, 1);
    step();
    i_rd_req  = 1'b0;
    i_wr_addr = 20'h00777;
    i_wr_data = 16'hAAAA;
    i_wr_req  = 1'b1;
    step();
    i_wr_req = 1'b0;
    wait_idle("t6");
    for (int k = 0; k < 5; k++) step();
    check("t6_no_wr_ack",   wr_ack_cnt, saved_wack);
    check("t6_no_mem_write", mem_write_cnt, saved_mw);

    // ---- 4: reset in the middle of a read WAIT ----
    resp_en = 1'b0;
    step();
    i_rd_addr = 20'h00123;
    i_rd_req  = 1'b1;
    #1;
    check("t4_ack", o_rd_ack, 1);
    step();
    i_rd_req = 1'b0;
    step();
    step();
    #1;
    check("t4_in_wait", o_busy, 1);
    step();
    i_rst = 1'b1;
    #1;
    check("t4_rst_busy",   o_busy, 0);
    check("t4_rst_addr",   o_mem_addr, 0);
    check("t4_rst_data",   o_rd_data, 0);
    check("t4_rst_strobe", o_mem_read, 0);
    sb.delete();
    saved_valid = rd_valid_cnt;
    step();
    i_rst = 1'b0;
    #1;
    inject_fin = 1'b1;            // late completion of the dropped access
    step();
    #1;
    check("t4_late_fin_idle", o_busy, 0);
    for (int k = 0; k < 4; k++) step();
    check("t4_no_valid", rd_valid_cnt, saved_valid);
    resp_en   = 1'b1;
    fin_delay = 2;
    do_read(20'h00123, "t4_after");

`ifdef SRAM_ARB_TIMEOUT_EN
    // ---- 5: WAIT timeout ----
    resp_en        = 1'b0;
    expect_timeout = 1'b1;
    step();
    i_rd_addr = 20'h00123;
    i_rd_req  = 1'b1;
    #1;
    check("t5_ack", o_rd_ack, 1);
    step();
    i_rd_req = 1'b0;
    n = 1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (o_rd_valid) begin
        got = 1'b1;
        break;
      end
      step();
      n++;
    end
    check("t5_valid_seen", got, 1);
    check("t5_latency",    n, 17);
    check("t5_err",        o_err, 1);
    check("t5_data_zero",  o_rd_data, 0);
    check("t5_idle",       o_busy, 0);
    wait_idle("t5");
    expect_timeout = 1'b0;
    resp_en        = 1'b1;
    do_read(20'h00123, "t5_after");
    check("t5_err_sticky", o_err, 1);
`else
    check("err_tied_low", o_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
